// File: rtl/pipeline_hazard_controller_pkg.sv
// Opcode map, FSM state encoding and decode helpers shared by the hazard controller.
package pipeline_hazard_controller_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_NOP   = 5'b00000;
  localparam opcode_t OP_ADD   = 5'b00001;
  localparam opcode_t OP_LOAD  = 5'b01000;
  localparam opcode_t OP_STORE = 5'b01001;
  localparam opcode_t OP_JMP   = 5'b10000;
  localparam opcode_t OP_JZ    = 5'b10001;
  localparam opcode_t OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_HALT     = 3'd3,
    ST_ERROR    = 3'd4
  } hz_state_e;

  function automatic logic is_memop(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over increment.
module pipeline_hazard_controller_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && !(&count_q)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stalls, bubbles and flushes the 4-stage pipeline around memory waits, taken jumps and HALT;
// owns the data-memory req/ack handshake, a saturating stall counter and a sticky timeout flag.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 10,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_instruction_execute,
  input  logic        i_valid_execute,
  input  logic        i_branch_taken,
  input  logic        i_resume,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_stall_fetch,
  output logic        o_stall_read,
  output logic        o_stall_execute,
  output logic        o_bubble_write,
  output logic        o_flush,
  output logic        o_halted,
  output logic        o_timeout_error,
  output logic [15:0] o_stall_count
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || DATA_SIZE < 1 || ADDRESS_SIZE < 1) begin : g_param_check
    $error("pipeline_hazard_controller: parameter out of range");
  end

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  hz_state_e state_q, state_d;
  logic      halt_skip_q, halt_skip_d;
  opcode_t   op;
  logic      memop, halt_op;
  logic      mem_req, mem_we, stall_all, flush;
  logic      to_clr, to_inc;
  logic [7:0] to_count;
  logic      unused_operand_bits;

  assign op                  = i_instruction_execute[15:11];
  assign unused_operand_bits = ^i_instruction_execute[10:0];
  assign memop               = i_valid_execute && is_memop(op);
  // The HALT that was just resumed is still in execute for one cycle; let it drain.
  assign halt_op             = i_valid_execute && (op == OP_HALT) && !halt_skip_q;

  always_comb begin
    state_d     = state_q;
    halt_skip_d = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    stall_all   = 1'b0;
    flush       = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_req = memop;
        mem_we  = memop && (op == OP_STORE);
        if (memop && !i_mem_ack) begin
          stall_all = 1'b1;
          to_clr    = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else if (halt_op) begin
          stall_all = 1'b1;
          state_d   = ST_HALT;
        end else if (i_valid_execute && i_branch_taken && !memop && (op != OP_HALT)) begin
          flush   = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_STORE);
        if (i_mem_ack) begin
          state_d = ST_RUN;
        end else begin
          stall_all = 1'b1;
          if (to_count == TO_LAST) begin
            state_d = ST_ERROR;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        state_d = ST_RUN;
      end
      ST_HALT: begin
        stall_all = 1'b1;
        if (i_resume) begin
          state_d     = ST_RUN;
          halt_skip_d = 1'b1;
        end
      end
      default: begin
        stall_all = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      halt_skip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_skip_q <= halt_skip_d;
    end
  end

  pipeline_hazard_controller_sat_counter #(.WIDTH(8)) u_timeout_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (to_clr),
    .i_inc   (to_inc),
    .o_count (to_count)
  );

  pipeline_hazard_controller_sat_counter #(.WIDTH(16)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_inc   (o_stall_execute),
    .o_count (o_stall_count)
  );

  // Combinational controls are masked by reset so a request drops the instant reset asserts.
  assign o_mem_req       = mem_req & i_rst_n;
  assign o_mem_we        = mem_we & i_rst_n;
  assign o_stall_fetch   = stall_all & i_rst_n;
  assign o_stall_read    = stall_all & i_rst_n;
  assign o_stall_execute = stall_all & i_rst_n;
  assign o_bubble_write  = stall_all & i_rst_n;
  assign o_flush         = flush & i_rst_n;
  assign o_halted        = (state_q == ST_HALT);
  assign o_timeout_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboarded bench: directed hazard scenarios then random traffic against a rule-level model.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int MD_RUN = 0, MD_WAIT = 1, MD_FLUSH = 2, MD_HALT = 3, MD_ERR = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        stall;
    logic        flush;
    logic        halted;
    logic        terr;
    logic [15:0] cnt;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_instruction_execute;
  logic        i_valid_execute, i_branch_taken, i_resume, i_mem_ack;
  logic        o_mem_req, o_mem_we, o_stall_fetch, o_stall_read, o_stall_execute;
  logic        o_bubble_write, o_flush, o_halted, o_timeout_error;
  logic [15:0] o_stall_count;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  int m_mode = MD_RUN;
  int m_waited = 0;
  int m_cnt = 0;
  bit m_skip = 1'b0;
  bit m_last_stall = 1'b0;

  always #5 i_clk = ~i_clk;

  pipeline_hazard_controller #(.DATA_SIZE(32), .ADDRESS_SIZE(10), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_instruction_execute(i_instruction_execute), .i_valid_execute(i_valid_execute),
    .i_branch_taken(i_branch_taken), .i_resume(i_resume), .i_mem_ack(i_mem_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_stall_fetch(o_stall_fetch), .o_stall_read(o_stall_read),
    .o_stall_execute(o_stall_execute), .o_bubble_write(o_bubble_write),
    .o_flush(o_flush), .o_halted(o_halted), .o_timeout_error(o_timeout_error),
    .o_stall_count(o_stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: one call per clock, returns what the outputs must show in that cycle.
  task automatic model_step(input bit v, input opcode_t op, input bit br, input bit res,
                            input bit ack, output exp_t e);
    bit mem, hlt;
    int nxt;
    mem = v && (op == OP_LOAD || op == OP_STORE);
    hlt = v && (op == OP_HALT);
    e = '0;
    e.cnt = m_cnt[15:0];
    e.halted = (m_mode == MD_HALT);
    e.terr = (m_mode == MD_ERR);
    nxt = m_mode;
    case (m_mode)
      MD_RUN: begin
        e.req = mem;
        e.we = mem && (op == OP_STORE);
        if (mem && !ack) begin
          e.stall = 1'b1; nxt = MD_WAIT; m_waited = 0;
        end else if (hlt && !m_skip) begin
          e.stall = 1'b1; nxt = MD_HALT;
        end else if (v && br && !mem && !hlt) begin
          e.flush = 1'b1; nxt = MD_FLUSH;
        end
      end
      MD_WAIT: begin
        e.req = 1'b1;
        e.we = (op == OP_STORE);
        if (ack) nxt = MD_RUN;
        else begin
          e.stall = 1'b1;
          m_waited++;
          if (m_waited >= MEM_TIMEOUT) nxt = MD_ERR;
        end
      end
      MD_FLUSH: begin
        e.flush = 1'b1; nxt = MD_RUN;
      end
      MD_HALT: begin
        e.stall = 1'b1;
        if (res) nxt = MD_RUN;
      end
      default: e.stall = 1'b1;
    endcase
    m_skip = (m_mode == MD_HALT) && res;
    if (e.stall && m_cnt < 65535) m_cnt++;
    m_last_stall = e.stall;
    m_mode = nxt;
  endtask

  task automatic set_inputs(input bit v, input opcode_t op, input bit br, input bit res, input bit ack);
    i_valid_execute = v;
    i_instruction_execute = {op, 11'($urandom)};
    i_branch_taken = br;
    i_resume = res;
    i_mem_ack = ack;
  endtask

  task automatic drive(input bit v, input opcode_t op, input bit br, input bit res, input bit ack);
    exp_t e;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    set_inputs(v, op, br, res, ack);
    model_step(v, op, br, res, ack, e);
    exp_q.push_back(e);
  endtask

  task automatic drive_rst(input bit v, input opcode_t op, input bit ack);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    set_inputs(v, op, 1'b0, 1'b0, ack);
    m_mode = MD_RUN; m_waited = 0; m_cnt = 0; m_skip = 1'b0; m_last_stall = 1'b0;
    exp_q.push_back('0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_req", 32'(o_mem_req), 32'(e.req));
        if (e.req) chk("mem_we", 32'(o_mem_we), 32'(e.we));
        chk("stall_fetch", 32'(o_stall_fetch), 32'(e.stall));
        chk("stall_read", 32'(o_stall_read), 32'(e.stall));
        chk("stall_execute", 32'(o_stall_execute), 32'(e.stall));
        chk("bubble_write", 32'(o_bubble_write), 32'(e.stall));
        chk("flush", 32'(o_flush), 32'(e.flush));
        chk("halted", 32'(o_halted), 32'(e.halted));
        chk("timeout_error", 32'(o_timeout_error), 32'(e.terr));
        chk("stall_count", 32'(o_stall_count), 32'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    bit rv;
    opcode_t rop;
    i_rst_n = 1'b0;
    set_inputs(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0);
    #2;
    chk("req_in_reset", 32'(o_mem_req), 32'd0);

    // LOAD waiting across reset release, then reset again mid-access
    drive_rst(1'b1, OP_LOAD, 1'b0);
    drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0);
    drive_rst(1'b1, OP_LOAD, 1'b0);
    #1;
    chk("req_async_drop", 32'(o_mem_req), 32'd0);
    chk("cnt_after_reset", 32'(o_stall_count), 32'd0);

    // zero-wait STORE, then LOAD acked after three stalled cycles
    drive(1'b1, OP_STORE, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b1);
    drive(1'b0, OP_NOP, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cnt_load3", 32'(o_stall_count), 32'd3);

    // timeout into ERROR, late ack ignored
    drive_rst(1'b0, OP_NOP, 1'b0);
    repeat (5) drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, OP_LOAD, 1'b0, 1'b0, 1'b1);
    #1;
    chk("terr_sticky", 32'(o_timeout_error), 32'd1);
    chk("req_in_error", 32'(o_mem_req), 32'd0);

    // taken jump flushes two cycles; branch alongside LOAD is ignored
    drive_rst(1'b0, OP_NOP, 1'b0);
    drive(1'b1, OP_JMP, 1'b1, 1'b0, 1'b0);
    drive(1'b0, OP_NOP, 1'b1, 1'b0, 1'b0);
    drive(1'b0, OP_NOP, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_LOAD, 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_LOAD, 1'b1, 1'b0, 1'b1);

    // HALT for ten cycles then resume
    drive_rst(1'b0, OP_NOP, 1'b0);
    drive(1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
    repeat (9) drive(1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_HALT, 1'b0, 1'b1, 1'b0);
    drive(1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cnt_halt11", 32'(o_stall_count), 32'd11);

    // saturation of the stall counter
    drive_rst(1'b0, OP_NOP, 1'b0);
    repeat (65540) drive(1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cnt_saturated", 32'(o_stall_count), 32'hFFFF);
    drive(1'b1, OP_HALT, 1'b0, 1'b1, 1'b0);
    drive(1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);

    // random traffic; the execute instruction is held while the pipeline is stalled
    drive_rst(1'b0, OP_NOP, 1'b0);
    rv = 1'b0;
    rop = OP_NOP;
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == MD_ERR && $urandom_range(0, 3) == 0) begin
        drive_rst(rv, rop, 1'b0);
      end else begin
        if (!m_last_stall) begin
          rv = ($urandom_range(0, 9) < 8);
          case ($urandom_range(0, 9))
            0, 1:    rop = OP_LOAD;
            2:       rop = OP_STORE;
            3:       rop = OP_HALT;
            4, 5:    rop = OP_JMP;
            default: rop = OP_ADD;
          endcase
        end
        drive(rv, rop, $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 4);
      end
    end

    repeat (3) @(negedge i_clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
